// File: rtl/gameboy_soc.sv
// Minimal Game Boy style system: on-chip memories plus a multi-cycle SM83-subset CPU
// executing from work RAM, with one status LED driven by stores to 0xFF00.
module gameboy_soc (
    input  logic clk,
    input  logic rst,
    output logic led
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        IMM_LO = 3'd2,
        IMM_HI = 3'd3,
        MEM_RD = 3'd4,
        MEM_WR = 3'd5,
        HALTED = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        RGN_WRAM  = 3'd0,
        RGN_VRAM  = 3'd1,
        RGN_UNMAP = 3'd2,
        RGN_IO    = 3'd3,
        RGN_HRAM  = 3'd4
    } region_t;

    logic [7:0] wRam        [32768];
    logic [7:0] vRam        [16384];
    logic [7:0] IORegisters [128];
    logic [7:0] hRam        [128];

    state_t      state_reg;
    logic [15:0] pc_reg;
    logic [7:0]  a_reg;
    logic [7:0]  opcode_reg;
    logic [7:0]  lo_reg;
    logic [7:0]  hi_reg;
    logic        phase_reg;
    logic        led_reg;

    logic [15:0] bus_addr;
    logic        bus_we;
    region_t     region;
    region_t     rd_sel_reg;
    logic [7:0]  wram_q_reg;
    logic [7:0]  vram_q_reg;
    logic [7:0]  io_q_reg;
    logic [7:0]  hram_q_reg;
    logic [7:0]  rd_data;

    assign led = led_reg;

    // The CPU is the only bus master; writes are gated by reset so an aborted store never lands.
    always_comb begin
        bus_addr = pc_reg;
        bus_we   = 1'b0;
        case (state_reg)
            MEM_RD: bus_addr = {hi_reg, lo_reg};
            MEM_WR: begin
                bus_addr = {hi_reg, lo_reg};
                bus_we   = ~rst;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (!bus_addr[15])
            region = RGN_WRAM;
        else if (!bus_addr[14])
            region = RGN_VRAM;
        else if (bus_addr[15:8] != 8'hFF)
            region = RGN_UNMAP;
        else if (!bus_addr[7])
            region = RGN_IO;
        else
            region = RGN_HRAM;
    end

    always_ff @(posedge clk) begin
        wram_q_reg <= wRam[bus_addr[14:0]];
        if (bus_we && region == RGN_WRAM)
            wRam[bus_addr[14:0]] <= a_reg;
    end

    always_ff @(posedge clk) begin
        vram_q_reg <= vRam[bus_addr[13:0]];
        if (bus_we && region == RGN_VRAM)
            vRam[bus_addr[13:0]] <= a_reg;
    end

    always_ff @(posedge clk) begin
        io_q_reg <= IORegisters[bus_addr[6:0]];
        if (bus_we && region == RGN_IO)
            IORegisters[bus_addr[6:0]] <= a_reg;
    end

    always_ff @(posedge clk) begin
        hram_q_reg <= hRam[bus_addr[6:0]];
        if (bus_we && region == RGN_HRAM)
            hRam[bus_addr[6:0]] <= a_reg;
    end

    always_ff @(posedge clk) begin
        rd_sel_reg <= region;
    end

    always_comb begin
        case (rd_sel_reg)
            RGN_WRAM: rd_data = wram_q_reg;
            RGN_VRAM: rd_data = vram_q_reg;
            RGN_IO:   rd_data = io_q_reg;
            RGN_HRAM: rd_data = hram_q_reg;
            default:  rd_data = 8'hFF;
        endcase
    end

    // Operand and memory-read states take two clocks each: phase 0 drives the address, phase 1 latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= FETCH;
            pc_reg     <= 16'h0000;
            a_reg      <= 8'h00;
            opcode_reg <= 8'h00;
            lo_reg     <= 8'h00;
            hi_reg     <= 8'h00;
            phase_reg  <= 1'b0;
            led_reg    <= 1'b0;
        end else begin
            case (state_reg)
                FETCH: begin
                    pc_reg    <= pc_reg + 16'd1;
                    state_reg <= DECODE;
                end
                DECODE: begin
                    opcode_reg <= rd_data;
                    phase_reg  <= 1'b0;
                    case (rd_data)
                        8'h3C: begin
                            a_reg     <= a_reg + 8'd1;
                            state_reg <= FETCH;
                        end
                        8'h3E, 8'hC3, 8'hEA, 8'hFA: state_reg <= IMM_LO;
                        8'h76:   state_reg <= HALTED;
                        default: state_reg <= FETCH;
                    endcase
                end
                IMM_LO: begin
                    if (!phase_reg) begin
                        pc_reg    <= pc_reg + 16'd1;
                        phase_reg <= 1'b1;
                    end else begin
                        phase_reg <= 1'b0;
                        if (opcode_reg == 8'h3E) begin
                            a_reg     <= rd_data;
                            state_reg <= FETCH;
                        end else begin
                            lo_reg    <= rd_data;
                            state_reg <= IMM_HI;
                        end
                    end
                end
                IMM_HI: begin
                    if (!phase_reg) begin
                        pc_reg    <= pc_reg + 16'd1;
                        phase_reg <= 1'b1;
                    end else begin
                        phase_reg <= 1'b0;
                        hi_reg    <= rd_data;
                        case (opcode_reg)
                            8'hC3: begin
                                pc_reg    <= {rd_data, lo_reg};
                                state_reg <= FETCH;
                            end
                            8'hEA:   state_reg <= MEM_WR;
                            default: state_reg <= MEM_RD;
                        endcase
                    end
                end
                MEM_RD: begin
                    if (!phase_reg) begin
                        phase_reg <= 1'b1;
                    end else begin
                        phase_reg <= 1'b0;
                        a_reg     <= rd_data;
                        state_reg <= FETCH;
                    end
                end
                MEM_WR: begin
                    if ({hi_reg, lo_reg} == 16'hFF00)
                        led_reg <= a_reg[0];
                    state_reg <= FETCH;
                end
                HALTED: state_reg <= HALTED;
                default: state_reg <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_gameboy_soc.sv
// Directed bench for gameboy_soc: preloads memories hierarchically, runs short programs
// and checks CPU state, memories and the LED against hand-computed values.
module tb_gameboy_soc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_IMM_HI = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd6;

    gameboy_soc dut (
        .clk (clk),
        .rst (rst),
        .led (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_test();
        rst = 1'b1;
        run(1);
        for (int i = 0; i < 32768; i++) dut.wRam[i] = 8'h00;
        for (int i = 0; i < 16384; i++) dut.vRam[i] = 8'h00;
        for (int i = 0; i < 128; i++) begin
            dut.IORegisters[i] = 8'h00;
            dut.hRam[i]        = 8'h00;
        end
    endtask

    task automatic release_reset();
        run(15);
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        logic [7:0] acc;

        // Test 1: all-zero memory executes NOPs
        begin_test();
        release_reset();
        chk("t1_reset_pc", dut.pc_reg, 16'h0000);
        chk("t1_reset_a", {8'h00, dut.a_reg}, 16'h0000);
        chk("t1_reset_state", {13'd0, 3'(dut.state_reg)}, {13'd0, S_FETCH});
        chk("t1_reset_led", {15'd0, led}, 16'h0000);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            run(1);
            if (led !== 1'b0) bad++;
        end
        chk("t1_pc_after_1024", dut.pc_reg, 16'h0200);
        chk("t1_a_after_1024", {8'h00, dut.a_reg}, 16'h0000);
        chk("t1_led_never_set", bad[15:0], 16'h0000);
        acc = 8'h00;
        for (int i = 0; i < 32768; i++) acc |= dut.wRam[i];
        for (int i = 0; i < 16384; i++) acc |= dut.vRam[i];
        for (int i = 0; i < 128; i++) acc |= dut.IORegisters[i] | dut.hRam[i];
        chk("t1_mem_unchanged", {8'h00, acc}, 16'h0000);

        // Test 2a: store 0x5A to 0xFF00, LED stays low
        begin_test();
        dut.wRam[0] = 8'h3E; dut.wRam[1] = 8'h5A; dut.wRam[2] = 8'hEA;
        dut.wRam[3] = 8'h00; dut.wRam[4] = 8'hFF; dut.wRam[5] = 8'h76;
        release_reset();
        run(4);
        chk("t2a_a_loaded", {8'h00, dut.a_reg}, 16'h005A);
        chk("t2a_pc_after_ld", dut.pc_reg, 16'h0002);
        run(7);
        chk("t2a_io0", {8'h00, dut.IORegisters[0]}, 16'h005A);
        chk("t2a_led", {15'd0, led}, 16'h0000);
        acc = 8'h00;
        for (int i = 0; i < 16384; i++) acc |= dut.vRam[i];
        chk("t2a_vram_untouched", {8'h00, acc}, 16'h0000);
        run(2);
        chk("t2a_halt_pc", dut.pc_reg, 16'h0006);
        chk("t2a_halt_state", {13'd0, 3'(dut.state_reg)}, {13'd0, S_HALTED});

        // Test 2b: store 0x5B, LED rises right after the write cycle, HALT holds
        begin_test();
        dut.wRam[0] = 8'h3E; dut.wRam[1] = 8'h5B; dut.wRam[2] = 8'hEA;
        dut.wRam[3] = 8'h00; dut.wRam[4] = 8'hFF; dut.wRam[5] = 8'h76;
        release_reset();
        run(10);
        chk("t2b_led_before_write", {15'd0, led}, 16'h0000);
        run(1);
        chk("t2b_led_after_write", {15'd0, led}, 16'h0001);
        chk("t2b_io0", {8'h00, dut.IORegisters[0]}, 16'h005B);
        run(2);
        chk("t2b_halt_pc", dut.pc_reg, 16'h0006);
        run(20);
        chk("t2b_halt_pc_held", dut.pc_reg, 16'h0006);
        chk("t2b_led_held", {15'd0, led}, 16'h0001);

        // Test 3: JP to 0x1000, INC A, HALT
        begin_test();
        dut.wRam[0] = 8'hC3; dut.wRam[1] = 8'h00; dut.wRam[2] = 8'h10;
        dut.wRam[16'h1000] = 8'h3C; dut.wRam[16'h1001] = 8'h76;
        release_reset();
        run(5);
        chk("t3_pc_clock5", dut.pc_reg, 16'h0003);
        run(1);
        chk("t3_pc_clock6", dut.pc_reg, 16'h1000);
        run(2);
        chk("t3_a_after_inc", {8'h00, dut.a_reg}, 16'h0001);
        run(2);
        chk("t3_halted", {13'd0, 3'(dut.state_reg)}, {13'd0, S_HALTED});
        chk("t3_halt_pc", dut.pc_reg, 16'h1002);

        // Test 4: VRAM load, HRAM store, unmapped load
        begin_test();
        dut.vRam[16'h0123] = 8'h77;
        dut.wRam[0] = 8'hFA; dut.wRam[1] = 8'h23; dut.wRam[2] = 8'h81;
        dut.wRam[3] = 8'hEA; dut.wRam[4] = 8'h80; dut.wRam[5] = 8'hFF;
        dut.wRam[6] = 8'hFA; dut.wRam[7] = 8'h00; dut.wRam[8] = 8'hC0;
        release_reset();
        run(7);
        chk("t4_a_before_latch", {8'h00, dut.a_reg}, 16'h0000);
        run(1);
        chk("t4_a_from_vram", {8'h00, dut.a_reg}, 16'h0077);
        run(7);
        chk("t4_hram0", {8'h00, dut.hRam[0]}, 16'h0077);
        run(8);
        chk("t4_a_unmapped", {8'h00, dut.a_reg}, 16'h00FF);
        chk("t4_pc_end", dut.pc_reg, 16'h0009);
        chk("t4_vram_kept", {8'h00, dut.vRam[16'h0123]}, 16'h0077);

        // Test 5: reset during the store's address phase aborts it
        begin_test();
        dut.wRam[0] = 8'h3E; dut.wRam[1] = 8'h01; dut.wRam[2] = 8'hEA;
        dut.wRam[3] = 8'h00; dut.wRam[4] = 8'hFF;
        dut.IORegisters[0] = 8'hAA;
        release_reset();
        run(9);
        chk("t5_in_addr_phase", {13'd0, 3'(dut.state_reg)}, {13'd0, S_IMM_HI});
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        chk("t5_no_store", {8'h00, dut.IORegisters[0]}, 16'h00AA);
        chk("t5_led", {15'd0, led}, 16'h0000);
        chk("t5_pc", dut.pc_reg, 16'h0000);
        chk("t5_state", {13'd0, 3'(dut.state_reg)}, {13'd0, S_FETCH});
        run(11);
        chk("t5_rerun_store", {8'h00, dut.IORegisters[0]}, 16'h0001);
        chk("t5_rerun_led", {15'd0, led}, 16'h0001);

        // Test 6: INC A wraps, unknown opcode acts as NOP
        begin_test();
        dut.wRam[0] = 8'h3E; dut.wRam[1] = 8'hFF; dut.wRam[2] = 8'h3C;
        dut.wRam[3] = 8'h01; dut.wRam[4] = 8'h76;
        release_reset();
        run(4);
        chk("t6_a_ff", {8'h00, dut.a_reg}, 16'h00FF);
        run(2);
        chk("t6_a_wrap", {8'h00, dut.a_reg}, 16'h0000);
        chk("t6_pc_before_op01", dut.pc_reg, 16'h0003);
        run(1);
        chk("t6_op01_decode", {13'd0, 3'(dut.state_reg)}, {13'd0, S_DECODE});
        run(1);
        chk("t6_op01_pc", dut.pc_reg, 16'h0004);
        chk("t6_op01_state", {13'd0, 3'(dut.state_reg)}, {13'd0, S_FETCH});
        chk("t6_op01_a", {8'h00, dut.a_reg}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
